captura_sensores: RTL and testbench



---
 rtl/captura_pkg.sv | 19 +
 rtl/captura_sensores_antirrebote.sv | 69 ++++++
 rtl/captura_sensores.sv | 110 +++++++++++
 tb/tb_captura_sensores.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/captura_pkg.sv
// captura_pkg: shared constants for the sensor capture front-end.
//   - FSM state encoding (INIT, REPOSO, ALERTA)
//   - default debounce length
//   - channel index map into the per-channel vectors
package captura_pkg;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_REPOSO = 2'd1;
    localparam logic [1:0] ST_ALERTA = 2'd2;

    localparam int DEB_CYCLES_DEF = 4;

    localparam int N_CH       = 4;
    localparam int CH_T_ALTA  = 0;
    localparam int CH_T_MEDIA = 1;
    localparam int CH_HUMO    = 2;
    localparam int CH_ELEC    = 3;

endpackage

// File: rtl/captura_sensores_antirrebote.sv
// antirrebote: one sensor channel.
//   2-flop synchronizer -> debounce counter -> level register -> strobe register.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_raw        : raw asynchronous sensor line
//   i_force      : forces a strobe next cycle (used while the FSM is in INIT)
//   o_level      : debounced level (flop output)
//   o_strobe     : one-cycle strobe, the cycle after a level change (flop output)
module antirrebote
    import captura_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    input  logic i_force,
    output logic o_level,
    output logic o_strobe
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [DEB_W-1:0] r_cnt;
    logic             r_level;
    logic             r_changed;
    logic             r_strobe;

    logic w_differs;
    logic w_accept;

    assign w_differs = (r_sync2 != r_level);
    // The current differing sample is the DEB_CYCLES-th in a row.
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_changed <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;

            if (!w_differs || w_accept)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (w_accept)
                r_level <= ~r_level;

            // Strobe lags the level by one cycle so downstream capture flops
            // see data that has been stable for a full period.
            r_changed <= w_accept;
            r_strobe  <= r_changed | i_force;
        end
    end

    assign o_level  = r_level;
    assign o_strobe = r_strobe;

endmodule

// File: rtl/captura_sensores.sv
// captura_sensores: sensor front-end for the fire-suppression controller.
//   Four debounced channels plus the alarm FSM that emits reset_cont on
//   alarm entry/exit and the initial load pulse after reset.
// Ports:
//   clk, reset_n                           : clock, asynchronous active-low reset
//   t_alta_in, t_media_in, humo_in, elec_in: raw sensor lines
//   T_alta, T_media, Humo, Elec            : debounced levels
//   acti_t_alta, Acti_t_media, Acti_humo, Acti_elec : one-cycle activation strobes
//   reset_cont                             : one-cycle counter-reset pulse
//
// state  | meaning
// INIT   | after reset; forces all strobes and reset_cont to load zeros downstream
// REPOSO | no sensor level active
// ALERTA | at least one sensor level active
module captura_sensores
    import captura_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic t_alta_in,
    input  logic t_media_in,
    input  logic humo_in,
    input  logic elec_in,
    output logic T_alta,
    output logic T_media,
    output logic Humo,
    output logic Elec,
    output logic acti_t_alta,
    output logic Acti_t_media,
    output logic Acti_humo,
    output logic Acti_elec,
    output logic reset_cont
);

    logic [N_CH-1:0] w_raw;
    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_strobe;
    logic            w_force;
    logic            w_any;

    logic [1:0]      r_state;
    logic            r_reset_cont;

    assign w_raw[CH_T_ALTA]  = t_alta_in;
    assign w_raw[CH_T_MEDIA] = t_media_in;
    assign w_raw[CH_HUMO]    = humo_in;
    assign w_raw[CH_ELEC]    = elec_in;

    assign w_force = (r_state == ST_INIT);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        antirrebote #(
            .DEB_CYCLES (DEB_CYCLES),
            .DEB_W      (DEB_W)
        ) u_antirrebote (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_raw    (w_raw[g]),
            .i_force  (w_force),
            .o_level  (w_level[g]),
            .o_strobe (w_strobe[g])
        );
    end

    // Evaluated on the already-registered new levels, so reset_cont lands in
    // the same cycle as the strobes of the channels that caused the change.
    assign w_any = |w_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_INIT;
            r_reset_cont <= 1'b0;
        end else begin
            r_reset_cont <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_state      <= ST_REPOSO;
                    r_reset_cont <= 1'b1;
                end
                ST_REPOSO: begin
                    if (w_any) begin
                        r_state      <= ST_ALERTA;
                        r_reset_cont <= 1'b1;
                    end
                end
                ST_ALERTA: begin
                    if (!w_any) begin
                        r_state      <= ST_REPOSO;
                        r_reset_cont <= 1'b1;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign T_alta       = w_level[CH_T_ALTA];
    assign T_media      = w_level[CH_T_MEDIA];
    assign Humo         = w_level[CH_HUMO];
    assign Elec         = w_level[CH_ELEC];
    assign acti_t_alta  = w_strobe[CH_T_ALTA];
    assign Acti_t_media = w_strobe[CH_T_MEDIA];
    assign Acti_humo    = w_strobe[CH_HUMO];
    assign Acti_elec    = w_strobe[CH_ELEC];
    assign reset_cont   = r_reset_cont;

endmodule

// File: tb/tb_captura_sensores.sv
// Self-checking bench for captura_sensores (DEB_CYCLES = 4).
module tb_captura_sensores;

    localparam int DEB = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] raw     = 4'b0000;   // bit0 t_alta, bit1 t_media, bit2 humo, bit3 elec

    logic T_alta, T_media, Humo, Elec;
    logic acti_t_alta, Acti_t_media, Acti_humo, Acti_elec;
    logic reset_cont;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    captura_sensores #(.DEB_CYCLES(DEB), .DEB_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .t_alta_in    (raw[0]),
        .t_media_in   (raw[1]),
        .humo_in      (raw[2]),
        .elec_in      (raw[3]),
        .T_alta       (T_alta),
        .T_media      (T_media),
        .Humo         (Humo),
        .Elec         (Elec),
        .acti_t_alta  (acti_t_alta),
        .Acti_t_media (Acti_t_media),
        .Acti_humo    (Acti_humo),
        .Acti_elec    (Acti_elec),
        .reset_cont   (reset_cont)
    );

    wire [3:0] o_lvl = {Elec, Humo, T_media, T_alta};
    wire [3:0] o_stb = {Acti_elec, Acti_humo, Acti_t_media, acti_t_alta};

    // ---------------- reference model ----------------
    // Raw samples arrive at the debouncer two clocks late. For each channel the
    // model keeps the list of consecutive samples disagreeing with the accepted
    // level; once DEB of them are collected the level flips. Strobe is "level
    // flipped on the previous edge"; reset_cont is "alarm status (any level
    // high) differs from what it was on the previous edge", plus the INIT pulse.
    logic [3:0] m_lvl, m_stb, m_flip, m_dly1, m_dly2;
    logic       m_rc, m_alarm, m_init;
    logic       m_q[4][$];

    task automatic model_reset();
        m_lvl = '0; m_stb = '0; m_flip = '0; m_dly1 = '0; m_dly2 = '0;
        m_rc = 1'b0; m_alarm = 1'b0; m_init = 1'b1;
        for (int c = 0; c < 4; c++) m_q[c].delete();
    endtask

    task automatic model_step();
        logic any_now;
        logic s;
        if (!reset_n) begin
            model_reset();
            return;
        end
        any_now = |m_lvl;
        m_stb   = m_flip | {4{m_init}};
        m_rc    = m_init | (any_now != m_alarm);
        m_alarm = any_now;
        m_init  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s = m_dly2[c];
            m_dly2[c] = m_dly1[c];
            m_dly1[c] = raw[c];
            m_flip[c] = 1'b0;
            if (s == m_lvl[c]) begin
                m_q[c].delete();
            end else begin
                m_q[c].push_back(s);
                if (m_q[c].size() == DEB) begin
                    m_lvl[c]  = ~m_lvl[c];
                    m_flip[c] = 1'b1;
                    m_q[c].delete();
                end
            end
        end
    endtask

    // One rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        raw = v;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (o_lvl !== 4'b0) begin failures++; $display("FAIL rst_levels got=%b exp=0000", o_lvl); end
        checks++; if (o_stb !== 4'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=0000", o_stb); end
        checks++; if (reset_cont !== 1'b0) begin failures++; $display("FAIL rst_reset_cont got=%b exp=0", reset_cont); end
        tick(); tick();
        @(negedge clk) reset_n = 1'b1;
        tick();
        checks++; if (o_stb !== 4'b1111) begin failures++; $display("FAIL init_strobes got=%b exp=1111", o_stb); end
        checks++; if (reset_cont !== 1'b1) begin failures++; $display("FAIL init_reset_cont got=%b exp=1", reset_cont); end
        checks++; if (o_lvl !== 4'b0) begin failures++; $display("FAIL init_levels got=%b exp=0000", o_lvl); end
        for (int k = 2; k <= 6; k++) begin
            tick();
            checks++;
            if (o_stb !== 4'b0 || reset_cont !== 1'b0 || o_lvl !== 4'b0) begin
                failures++;
                $display("FAIL post_init_quiet k=%0d stb=%b rc=%b lvl=%b exp all 0", k, o_stb, reset_cont, o_lvl);
            end
        end
    endtask

    task automatic test_short_pulse();
        drive(4'b1000);
        tick(); tick(); tick();
        drive(4'b0000);
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (Elec !== 1'b0 || Acti_elec !== 1'b0 || reset_cont !== 1'b0) begin
                failures++;
                $display("FAIL short_pulse k=%0d Elec=%b Acti_elec=%b rc=%b exp 0/0/0", k, Elec, Acti_elec, reset_cont);
            end
        end
    endtask

    task automatic test_humo_rise();
        drive(4'b0100);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (Humo !== 1'(k >= 6)) begin failures++; $display("FAIL humo_level k=%0d got=%b exp=%b", k, Humo, k >= 6); end
            checks++; if (Acti_humo !== 1'(k == 7)) begin failures++; $display("FAIL humo_strobe k=%0d got=%b exp=%b", k, Acti_humo, k == 7); end
            checks++; if (reset_cont !== 1'(k == 7)) begin failures++; $display("FAIL humo_reset_cont k=%0d got=%b exp=%b", k, reset_cont, k == 7); end
            checks++; if ((o_stb & 4'b1011) !== 4'b0) begin failures++; $display("FAIL humo_other_strobes k=%0d got=%b exp=0000", k, o_stb & 4'b1011); end
        end
    endtask

    task automatic test_swap_in_alerta();
        int n_rc;
        drive(4'b1000);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (Elec !== 1'(k >= 6) || Humo !== 1'(k < 6)) begin failures++; $display("FAIL swap_levels k=%0d Elec=%b Humo=%b", k, Elec, Humo); end
            checks++; if (o_stb !== ((k == 7) ? 4'b1100 : 4'b0000)) begin failures++; $display("FAIL swap_strobes k=%0d got=%b", k, o_stb); end
            checks++; if (reset_cont !== 1'b0) begin failures++; $display("FAIL swap_reset_cont k=%0d got=%b exp=0", k, reset_cont); end
        end
        drive(4'b0000);
        n_rc = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (reset_cont === 1'b1) n_rc++;
            checks++; if (reset_cont !== 1'(k == 7)) begin failures++; $display("FAIL exit_reset_cont k=%0d got=%b exp=%b", k, reset_cont, k == 7); end
        end
        checks++; if (n_rc != 1) begin failures++; $display("FAIL exit_rc_count got=%0d exp=1", n_rc); end
    endtask

    task automatic test_simultaneous();
        int n_rc;
        for (int phase = 0; phase < 2; phase++) begin
            drive(phase == 0 ? 4'b0011 : 4'b0000);
            n_rc = 0;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (reset_cont === 1'b1) n_rc++;
                checks++;
                if ({T_media, T_alta} !== ((phase == 0) == (k >= 6) ? 2'b11 : 2'b00)) begin
                    failures++; $display("FAIL simul_levels ph=%0d k=%0d got=%b", phase, k, {T_media, T_alta});
                end
                checks++;
                if (o_stb !== ((k == 7) ? 4'b0011 : 4'b0000)) begin
                    failures++; $display("FAIL simul_strobes ph=%0d k=%0d got=%b", phase, k, o_stb);
                end
            end
            checks++; if (n_rc != 1) begin failures++; $display("FAIL simul_rc_count ph=%0d got=%0d exp=1", phase, n_rc); end
        end
    endtask

    task automatic test_random();
        int hold[4];
        for (int c = 0; c < 4; c++) hold[c] = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    raw[c]  = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 9);
                end else begin
                    hold[c]--;
                end
            end
            tick();
            checks++;
            if (o_lvl !== m_lvl || o_stb !== m_stb || reset_cont !== m_rc) begin
                failures++;
                $display("FAIL random n=%0d lvl=%b/%b stb=%b/%b rc=%b/%b (got/exp)", n, o_lvl, m_lvl, o_stb, m_stb, reset_cont, m_rc);
            end
        end
        drive(4'b0000);
        for (int k = 0; k < 12; k++) tick();
        checks++; if (o_lvl !== 4'b0) begin failures++; $display("FAIL random_settle got=%b exp=0000", o_lvl); end
    endtask

    task automatic test_reset_mid();
        drive(4'b0001);
        tick(); tick(); tick(); tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (o_lvl !== 4'b0 || o_stb !== 4'b0 || reset_cont !== 1'b0) begin failures++; $display("FAIL mid_deb_reset lvl=%b stb=%b rc=%b exp 0", o_lvl, o_stb, reset_cont); end
        @(negedge clk) reset_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++; if (T_alta !== 1'(k >= 6)) begin failures++; $display("FAIL mid_relaunch_level k=%0d got=%b", k, T_alta); end
            checks++;
            if (o_stb !== ((k == 1) ? 4'b1111 : (k == 7) ? 4'b0001 : 4'b0000)) begin
                failures++; $display("FAIL mid_relaunch_strobes k=%0d got=%b", k, o_stb);
            end
            checks++; if (reset_cont !== 1'(k == 1 || k == 7)) begin failures++; $display("FAIL mid_relaunch_rc k=%0d got=%b", k, reset_cont); end
        end
        // reset landing on a strobe cycle
        drive(4'b0000);
        for (int k = 1; k <= 7; k++) tick();
        checks++; if (acti_t_alta !== 1'b1) begin failures++; $display("FAIL fall_strobe got=%b exp=1", acti_t_alta); end
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (o_stb !== 4'b0 || reset_cont !== 1'b0) begin failures++; $display("FAIL mid_strobe_reset stb=%b rc=%b exp 0", o_stb, reset_cont); end
        @(negedge clk) reset_n = 1'b1;
        tick();
        checks++; if (o_stb !== 4'b1111 || reset_cont !== 1'b1) begin failures++; $display("FAIL reinit stb=%b rc=%b exp 1111/1", o_stb, reset_cont); end
        for (int k = 2; k <= 8; k++) begin
            tick();
            checks++; if (o_stb !== 4'b0 || reset_cont !== 1'b0 || o_lvl !== 4'b0) begin failures++; $display("FAIL stale_strobe k=%0d stb=%b rc=%b lvl=%b", k, o_stb, reset_cont, o_lvl); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_short_pulse();
        test_humo_rise();
        test_swap_in_alerta();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
